// File: rtl/pipelined_shifter_if.sv
// Operand/result handshake bundle for pipelined_shifter.
// The shifter sits on the slave side; the producer/consumer uses master.
interface pipelined_shifter_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow control.
// Shift levels are grouped across STAGES register stages, largest shift first.
module pipelined_shifter #(
    parameter int WIDTH  = 32,
    parameter int AMT_W  = 32,
    parameter int STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    pipelined_shifter_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int GRP    = (LEVELS + STAGES - 1) / STAGES;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [1:0]        mode;
        logic              fill;
        logic              big;
        logic [LEVELS-1:0] sel;
    } op_t;

    op_t  in_op;
    logic adv;
    logic out_valid_w;

    // One mux level: shift by sh, filling with zeros, the sign bit or the rotated-out bits.
    function automatic logic [WIDTH-1:0] level_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             fill,
        input int               sh
    );
        logic [WIDTH-1:0] hi_mask;
        hi_mask = ~({WIDTH{1'b1}} >> sh);
        case (mode)
            MODE_SLL: level_shift = d << sh;
            MODE_ROR: level_shift = (d >> sh) | (d << (WIDTH - sh));
            default:  level_shift = (d >> sh) | (fill ? hi_mask : '0);
        endcase
    endfunction

    assign adv          = !out_valid_w || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        in_op.data = bus.in_data;
        in_op.mode = bus.in_mode;
        in_op.fill = (bus.in_mode == MODE_SRA) && bus.in_data[WIDTH-1];
        in_op.big  = (bus.in_amt >= AMT_W'(WIDTH));
        in_op.sel  = bus.in_amt[LEVELS-1:0];
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int HI = LEVELS - 1 - gi * GRP;
        localparam int LO = (HI - GRP + 1 < 0) ? 0 : HI - GRP + 1;

        op_t              src;
        logic             src_valid;
        logic [WIDTH-1:0] shf_d;
        logic             valid_q;

        if (gi == 0) begin : g_src
            assign src       = in_op;
            assign src_valid = bus.in_valid;
        end else begin : g_src
            assign src       = g_stage[gi-1].g_reg.op_q;
            assign src_valid = g_stage[gi-1].valid_q;
        end

        always_comb begin
            shf_d = src.data;
            for (int k = LEVELS - 1; k >= 0; k--) begin
                if (k <= HI && k >= LO && src.sel[k]) begin
                    shf_d = level_shift(shf_d, src.mode, src.fill, 1 << k);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else if (adv) begin
                valid_q <= src_valid;
            end
        end

        if (gi == STAGES - 1) begin : g_reg
            logic [WIDTH-1:0] res_d;
            logic [WIDTH-1:0] data_q;
            logic             zero_q;

            // Out-of-range linear shifts saturate to the fill bit; rotates wrap instead.
            always_comb begin
                res_d = shf_d;
                if (src.big && src.mode != MODE_ROR) begin
                    res_d = {WIDTH{src.fill}};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    data_q <= res_d;
                    zero_q <= (res_d == '0);
                end
            end

            assign bus.out_data  = data_q;
            assign bus.out_zero  = zero_q;
            assign bus.out_valid = valid_q;
            assign out_valid_w   = valid_q;
        end else begin : g_reg
            op_t op_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    op_q <= '0;
                end else if (adv) begin
                    op_q      <= src;
                    op_q.data <= shf_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// Drives three shifters (STAGES = 2, 1, 5) with identical stimulus and checks
// each against its own queue of expected results.
module tb_pipelined_shifter;
    localparam int W  = 32;
    localparam int AW = 32;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic [AW-1:0] in_amt    = '0;
    logic [1:0]    in_mode   = '0;
    logic          out_ready = 1'b1;

    always #5 clk = ~clk;

    pipelined_shifter_if #(.WIDTH(W), .AMT_W(AW)) bus0 ();
    pipelined_shifter_if #(.WIDTH(W), .AMT_W(AW)) bus1 ();
    pipelined_shifter_if #(.WIDTH(W), .AMT_W(AW)) bus2 ();

    pipelined_shifter #(.WIDTH(W), .AMT_W(AW), .STAGES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipelined_shifter #(.WIDTH(W), .AMT_W(AW), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipelined_shifter #(.WIDTH(W), .AMT_W(AW), .STAGES(5)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;  assign bus2.in_valid = in_valid;
    assign bus0.in_data  = in_data;   assign bus1.in_data  = in_data;   assign bus2.in_data  = in_data;
    assign bus0.in_amt   = in_amt;    assign bus1.in_amt   = in_amt;    assign bus2.in_amt   = in_amt;
    assign bus0.in_mode  = in_mode;   assign bus1.in_mode  = in_mode;   assign bus2.in_mode  = in_mode;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;

    logic        ov [3];
    logic        oz [3];
    logic        ir [3];
    logic [31:0] od [3];
    assign ov[0] = bus0.out_valid; assign ov[1] = bus1.out_valid; assign ov[2] = bus2.out_valid;
    assign oz[0] = bus0.out_zero;  assign oz[1] = bus1.out_zero;  assign oz[2] = bus2.out_zero;
    assign ir[0] = bus0.in_ready;  assign ir[1] = bus1.in_ready;  assign ir[2] = bus2.in_ready;
    assign od[0] = bus0.out_data;  assign od[1] = bus1.out_data;  assign od[2] = bus2.out_data;

    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        q2 [$];
    int          errors  = 0;
    int          checks  = 0;
    int          cyc     = 0;
    bit          lat_chk = 1'b0;
    bit          hold_v [3];
    logic [31:0] hold_d [3];

    // Directed vectors with hand-derived expected results.
    logic [31:0] dv_d [16] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                               32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                               32'hDEAD_BEEF, 32'h0000_00F1, 32'h0000_00F1, 32'h0000_00F1,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5679};
    logic [31:0] dv_a [16] = '{32'd4, 32'd31, 32'd40, 32'd40, 32'd32, 32'd0, 32'd0, 32'd0,
                               32'd0, 32'd4, 32'd36, 32'h8000_0004, 32'd31, 32'hFFFF_FFE0,
                               32'd40, 32'd31};
    logic [1:0]  dv_m [16] = '{SLL, SRA, SRA, SRL, SRL, SLL, SRL, SRA,
                               ROR, ROR, ROR, SLL, SRL, SLL, SRA, SLL};
    logic [31:0] dv_e [16] = '{32'h0000_0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,
                               32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                               32'hDEAD_BEEF, 32'h1000_000F, 32'h1000_000F, 32'h0000_0000,
                               32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};

    function automatic logic [31:0] model(input logic [31:0] d, input logic [31:0] a, input logic [1:0] m);
        logic signed [31:0] s;
        logic [63:0]        dd;
        int                 r;
        s  = d;
        dd = {d, d};
        r  = int'(a % 32);
        case (m)
            SLL:     return (a >= 32) ? 32'h0 : d << a;
            SRL:     return (a >= 32) ? 32'h0 : d >> a;
            SRA:     return (a >= 32) ? {32{d[31]}} : 32'(s >>> a);
            default: return dd[31:0] >> 0 == 0 ? 32'(dd >> r) : 32'(dd >> r);
        endcase
    endfunction

    function automatic logic [31:0] rand_amt();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 31));
            1:       return 32'($urandom_range(28, 40));
            2:       return $urandom;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 5;
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [31:0] e);
        exp_t x;
        x.data = e;
        x.acc  = cyc;
        case (i)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    task automatic pop_check(input int i);
        exp_t x;
        chk($sformatf("dut%0d_out_expected", i), 32'(qsize(i) != 0), 32'd1);
        if (qsize(i) != 0) begin
            case (i)
                0:       x = q0.pop_front();
                1:       x = q1.pop_front();
                default: x = q2.pop_front();
            endcase
            chk($sformatf("dut%0d_out_data", i), od[i], x.data);
            chk($sformatf("dut%0d_out_zero", i), 32'(oz[i]), 32'(x.data == 32'h0));
            if (lat_chk) chk($sformatf("dut%0d_latency", i), 32'(cyc - x.acc), 32'(lat_of(i)));
        end
    endtask

    // One clock cycle: present inputs at the falling edge, check, then cross the rising edge.
    task automatic tick(input logic v, input logic [31:0] d, input logic [31:0] a,
                        input logic [1:0] m, input logic [31:0] e, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_amt    = a;
        in_mode   = m;
        out_ready = ordy;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d_in_ready", i), 32'(ir[i]), 32'(!ov[i] || ordy));
            if (hold_v[i]) chk($sformatf("dut%0d_stall_hold", i), od[i], hold_d[i]);
            if (ov[i] && ordy) pop_check(i);
            if (v && ir[i] && !rst) push(i, e);
            hold_v[i] = ov[i] && !ordy && !rst;
            hold_d[i] = od[i];
        end
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic rand_tick(input logic v, input logic ordy);
        logic [31:0] d;
        logic [31:0] a;
        logic [1:0]  m;
        d = $urandom;
        a = rand_amt();
        m = 2'($urandom_range(0, 3));
        tick(v, d, a, m, model(d, a, m), ordy);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 32'h0, 32'h0, SLL, 32'h0, 1'b1);
    endtask

    task automatic check_drained(input string tag);
        for (int i = 0; i < 3; i++) chk($sformatf("dut%0d_%s_drained", i, tag), 32'(qsize(i)), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d_reset_valid", i), 32'(ov[i]), 32'd0);
            chk($sformatf("dut%0d_reset_data", i), od[i], 32'h0);
            chk($sformatf("dut%0d_reset_zero", i), 32'(oz[i]), 32'd0);
        end
        rst = 1'b0;

        // Directed boundary cases as one back-to-back burst, latency checked.
        lat_chk = 1'b1;
        for (int n = 0; n < 16; n++) tick(1'b1, dv_d[n], dv_a[n], dv_m[n], dv_e[n], 1'b1);
        idle(8);
        check_drained("directed");

        // Random traffic with random back-pressure.
        lat_chk = 1'b0;
        for (int n = 0; n < 80; n++) rand_tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
        idle(12);
        check_drained("random");

        // Three ops, then a four-cycle output stall while more ops are offered.
        for (int n = 0; n < 3; n++) rand_tick(1'b1, 1'b1);
        for (int n = 0; n < 4; n++) rand_tick(1'b1, 1'b0);
        idle(12);
        check_drained("stall");

        // Reset with two ops in flight; neither may reappear.
        tick(1'b1, 32'h0000_00F0, 32'd4, SLL, 32'h0000_0F00, 1'b0);
        tick(1'b1, 32'h0000_0003, 32'd1, SLL, 32'h0000_0006, 1'b0);
        rst = 1'b1;
        tick(1'b1, 32'h1234_5678, 32'd0, SLL, 32'h1234_5678, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d_midrst_valid", i), 32'(ov[i]), 32'd0);
            chk($sformatf("dut%0d_midrst_data", i), od[i], 32'h0);
        end
        idle(8);
        lat_chk = 1'b1;
        tick(1'b1, 32'h0000_0001, 32'd4, SLL, 32'h0000_0010, 1'b1);
        idle(8);
        check_drained("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the combinational barrel shifter feeding the ALU.
- Adds arithmetic-right and rotate-right modes and a configurable number of register stages.
- Uses valid/ready handshakes on input and output, so it can sit in the execute stage or as a multi-cycle ALU unit under stall control.
- Stage muxes shift by 2^k, processed most-significant level first, as in the existing shifter.

Parameters:
- WIDTH, 32: data width; power of two, 8..64.
- AMT_W, 32: width of the shift-amount input (full register value).
- STAGES, 2: register stages; 1..LEVELS, where LEVELS = log2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  AMT_W  shift amount, unsigned.
- in_mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  high when out_data == 0; qualified by out_valid.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - all stage valid bits, out_valid, out_data and out_zero go to 0 on the same edge;
  - in-flight operations are discarded;
  - rst overrides any simultaneous in_valid.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Pipeline advance enable is adv = !out_valid || out_ready.
  - All stages advance together on adv; in_ready = adv (combinational from out_ready).
  - Bubbles are not compressed while stalled.
  - When adv=0, every stage register, including out_data, holds.
  - out_data is stable while out_valid && !out_ready.
- Latency and throughput:
  - Exactly STAGES cycles from accepting edge to out_valid when out_ready stays 1.
  - One result per cycle sustained.
  - Results come out in acceptance order; no drops or duplicates.
- Level partitioning:
  - Level k shifts by 2^k, for k = LEVELS-1 down to 0.
  - Levels are grouped into STAGES groups of ceil(LEVELS/STAGES) levels each, the last group taking the remainder.
  - A register follows each group; the final register drives out_data and out_zero.
- Input-side decode (before stage 1), carried down the pipe with the data:
  - mode; fill bit (in_data[WIDTH-1] for SRA, else 0);
  - range flag big = (in_amt >= WIDTH), compared over all AMT_W bits;
  - per-level select bits = in_amt[LEVELS-1:0].
- Mode semantics:
  - SLL: zeros shifted in at LSB.
  - SRL: zeros shifted in at MSB.
  - SRA: fill bit shifted in at MSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Out-of-range amounts (big=1):
  - SLL/SRL result = 0.
  - SRA result = all bits equal to the fill bit.
  - ROR ignores big and rotates by in_amt mod WIDTH.
- Amount 0 passes in_data unchanged in all modes.
- Boundary: amount WIDTH-1 is in range; amount WIDTH is out of range (SLL/SRL give 0). Amounts with only upper bits set (e.g. 2^AMT_W-WIDTH) are out of range, not aliased.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1: SLL 0x0000_0001 by 4 → 0x0000_0010 with out_valid exactly 2 cycles after accept, out_zero=0.
- SRA 0x8000_0000 by 31 → 0xFFFF_FFFF; by 40 → 0xFFFF_FFFF. SRL 0x8000_0000 by 40 → 0x0000_0000 with out_zero=1. SRL by 32 → 0. Any mode by 0 → unchanged.
- ROR 0x0000_00F1 by 4 → 0x1000_000F; by 36 → 0x1000_000F; SLL 0x0000_00F1 by 0x1_0000_0000-scale amount (e.g. 0x8000_0004) → 0.
- Burst of 6 back-to-back ops with out_ready=1 → 6 consecutive out_valid cycles, results in order. Repeat with STAGES=1 and STAGES=5 → latency 1 and 5.
- Hold out_ready=0 for 4 cycles with 3 ops in flight → in_ready=0 from first stalled cycle and out_data stable; after release, all 3 results delivered in order with no loss or duplication.
- Assert rst for one cycle while 2 ops are in flight → out_valid=0 and out_data=0 on the next edge; neither op appears afterwards; the next accepted op completes with normal latency.
